// File: rtl/sipo_deserializer.sv
// Purpose : framed serial-in / parallel-out receiver with a one-word holding register.
// Latency : a word is visible on data_out/data_valid right after the edge that samples its last bit.
// Backpressure: data_valid/data_ready handshake; a word completing while the holder is full and
//               not being drained is dropped and flagged (sticky overflow).
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   serial_in, bit_valid  - serial bit and its qualifier
//   frame_start           - current valid bit is bit 0 of a word (resyncs mid-word)
//   data_out, data_valid  - assembled word and its valid flag
//   data_ready            - consumer accepts data_out when data_valid=1
//   busy                  - a word is partially received
//   overflow, frame_err   - sticky error flags, cleared by clear_flags (set wins)
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err,
  input  logic             clear_flags
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               ferr_q, ferr_d;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   first_word;
  logic               word_done;
  logic               ovf_set;
  logic               ferr_set;

  // Register contents after shifting serial_in in; on the last bit this is the finished word.
  assign shifted    = MSB_FIRST ? {shift_q[WIDTH-2:0], serial_in}
                                : {serial_in, shift_q[WIDTH-1:1]};
  // First bit of a frame is loaded into a cleared register so no stale bits linger.
  assign first_word = MSB_FIRST ? {{(WIDTH-1){1'b0}}, serial_in}
                                : {serial_in, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    word_done = 1'b0;
    ovf_set   = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        // Valid bits without frame_start are ignored while hunting for a frame.
        if (bit_valid && frame_start) begin
          shift_d = first_word;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            // Resync: abandon the partial word, this bit starts a new one.
            shift_d  = first_word;
            cnt_d    = CNT_W'(1);
            ferr_set = 1'b1;
          end else if (cnt_q == LAST_IDX) begin
            word_done = 1'b1;
            shift_d   = '0;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding register: a completing word may replace a word being accepted on the same edge.
    if (word_done) begin
      if (!valid_q || data_ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    // Sticky flags: clear first so a simultaneous set takes priority.
    if (clear_flags) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (ovf_set)  ovf_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: an MSB-first and an LSB-first instance share one input stream.
// A bit-list model predicts both on every cycle; directed literal checks pin the model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_sipo_deserializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         data_ready = 1'b0;
  logic         clear_flags = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic         dv_m, dv_l, busy_m, busy_l, ovf_m, ovf_l, ferr_m, ferr_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_m), .data_valid(dv_m),
    .data_ready(data_ready), .busy(busy_m), .overflow(ovf_m),
    .frame_err(ferr_m), .clear_flags(clear_flags));

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout_l), .data_valid(dv_l),
    .data_ready(data_ready), .busy(busy_l), .overflow(ovf_l),
    .frame_err(ferr_l), .clear_flags(clear_flags));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of received bits; n = how many bits of the current frame are in.
  int           n;
  bit           bits [W];
  bit           m_valid;
  logic [W-1:0] m_word_m, m_word_l;
  bit           m_ovf, m_ferr;

  // Bit k of the frame goes to position W-1-k (MSB first) or k (LSB first).
  function automatic logic [W-1:0] assemble(input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (msb_first) w[W-1-k] = bits[k];
      else           w[k]     = bits[k];
    end
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit done, accept, set_o, set_f;
    if (reset) begin
      n = 0; m_valid = 0; m_word_m = '0; m_word_l = '0; m_ovf = 0; m_ferr = 0;
    end else begin
      done = 0; set_o = 0; set_f = 0;
      accept = m_valid && data_ready;
      if (bit_valid) begin
        if (frame_start) begin
          if (n > 0) set_f = 1;
          bits[0] = serial_in;
          n = 1;
        end else if (n > 0) begin
          bits[n] = serial_in;
          n++;
          if (n == W) begin
            done = 1;
            n = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || data_ready) begin
          m_valid  = 1;
          m_word_m = assemble(1'b1);
          m_word_l = assemble(1'b0);
        end else begin
          set_o = 1;
        end
      end else if (accept) begin
        m_valid = 0;
      end
      if (clear_flags) begin m_ovf = 0; m_ferr = 0; end
      if (set_o) m_ovf = 1;
      if (set_f) m_ferr = 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("m_valid", {31'b0, dv_m}, {31'b0, m_valid});
      check("m_data", {24'b0, dout_m}, {24'b0, m_word_m});
      check("m_busy", {31'b0, busy_m}, {31'b0, n > 0});
      check("m_ovf", {31'b0, ovf_m}, {31'b0, m_ovf});
      check("m_ferr", {31'b0, ferr_m}, {31'b0, m_ferr});
      check("l_valid", {31'b0, dv_l}, {31'b0, m_valid});
      check("l_data", {24'b0, dout_l}, {24'b0, m_word_l});
      check("l_busy", {31'b0, busy_l}, {31'b0, n > 0});
      check("l_ovf", {31'b0, ovf_l}, {31'b0, m_ovf});
      check("l_ferr", {31'b0, ferr_l}, {31'b0, m_ferr});
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the falling edge after the bit is sampled.
  task automatic put(input bit b, input bit fs);
    serial_in = b; frame_start = fs; bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb_first, input int gap);
    for (int i = 0; i < W; i++) begin
      put(msb_first ? w[W-1-i] : w[i], i == 0);
      if (gap > 0 && i < W-1) idle(1 + (i % gap));
    end
  endtask

  task automatic chk_m(input string name, input logic [W-1:0] d, input bit v, input bit o, input bit f);
    check({name, "_data"}, {24'b0, dout_m}, {24'b0, d});
    check({name, "_valid"}, {31'b0, dv_m}, {31'b0, v});
    check({name, "_ovf"}, {31'b0, ovf_m}, {31'b0, o});
    check({name, "_ferr"}, {31'b0, ferr_m}, {31'b0, f});
  endtask

  initial begin
    idle(2);
    // Reset state.
    chk_m("rst", 8'h00, 0, 0, 0);
    check("rst_busy", {31'b0, busy_m}, 32'd0);
    reset = 1'b0;
    idle(1);

    // 1: back-to-back 0xAA, consumer always ready.
    data_ready = 1'b1;
    put(1, 1);
    check("t1_busy_first", {31'b0, busy_m}, 32'd1);
    for (int i = 1; i < W; i++) put(i[0] ? 1'b0 : 1'b1, 0);
    chk_m("t1", 8'hAA, 1, 0, 0);
    check("t1_busy_done", {31'b0, busy_m}, 32'd0);
    idle(1);
    check("t1_valid_one_cycle", {31'b0, dv_m}, 32'd0);

    // 2: stray bits before the frame, then 0xAA with 1..3 idle gaps.
    put(1, 0); put(1, 0);
    check("t2_no_hunt_busy", {31'b0, busy_m}, 32'd0);
    data_ready = 1'b0;
    send_word(8'hAA, 1'b1, 3);
    chk_m("t2", 8'hAA, 1, 0, 0);
    data_ready = 1'b1;
    idle(1);

    // 3: holder full -> second word dropped, overflow sticky until cleared.
    data_ready = 1'b0;
    send_word(8'h3C, 1'b1, 0);
    send_word(8'hC3, 1'b1, 0);
    chk_m("t3_held", 8'h3C, 1, 1, 0);
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
    check("t3_drain", {31'b0, dv_m}, 32'd0);
    check("t3_ovf_sticky", {31'b0, ovf_m}, 32'd1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("t3_ovf_clr", {31'b0, ovf_m}, 32'd0);

    // 4a: 3-bit partial word then resync with 0x5A.
    data_ready = 1'b1;
    put(1, 1); put(0, 0); put(1, 0);
    send_word(8'h5A, 1'b1, 0);
    chk_m("t4a", 8'h5A, 1, 0, 1);
    idle(1);
    // 4b: 0x11 pending, 0x5A completes on the cycle the consumer takes 0x11.
    data_ready = 1'b0;
    send_word(8'h11, 1'b1, 0);
    for (int i = 0; i < W; i++) begin
      if (i == W-1) data_ready = 1'b1;
      put(8'h5A >> (W-1-i), i == 0);
    end
    chk_m("t4b", 8'h5A, 1, 0, 1);
    idle(1);

    // 5: held word + 4 partial bits, then asynchronous reset mid-cycle.
    data_ready = 1'b0;
    send_word(8'h77, 1'b1, 0);
    put(1, 1); put(1, 0); put(0, 0); put(1, 0);
    #2 reset = 1'b1;
    #1;
    chk_m("t5_async", 8'h00, 0, 0, 0);
    check("t5_async_busy", {31'b0, busy_m}, 32'd0);
    check("t5_async_l", {23'b0, dv_l, dout_l}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    data_ready = 1'b1;
    send_word(8'hF0, 1'b1, 0);
    chk_m("t5_after", 8'hF0, 1, 0, 0);
    idle(1);

    // 6: LSB-first stream 0,1,1,0,1,0,0,1 -> 0x96 on the LSB-first instance.
    send_word(8'h96, 1'b0, 0);
    check("t6_lsb_data", {24'b0, dout_l}, 32'h96);
    check("t6_lsb_valid", {31'b0, dv_l}, 32'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. Collects a framed serial bit stream into WIDTH-bit words and presents each word on a parallel output with a valid/ready handshake.
- It is the receive end of the team's parallel-load shift register path. A parallel word serialized upstream is reassembled here.
- Has a one-word output holding register, framing resync, and sticky overflow and framing-error flags.

Parameters:
- WIDTH, 8: word width in bits. Must be at least 2.
- MSB_FIRST, 1: 1 means the first received bit lands in data_out[WIDTH-1] (shift left). 0 means the first bit lands in data_out[0] (shift right).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies serial_in for this cycle.
- frame_start  input  1  marks the current bit as bit 0 of a word; only meaningful with bit_valid=1.
- data_out  output  WIDTH  assembled word (holding register).
- data_valid  output  1  data_out holds a word not yet accepted.
- data_ready  input  1  consumer accepts the word when data_valid=1 and data_ready=1.
- busy  output  1  a word is partially received (state SHIFT).
- overflow  output  1  sticky; a completed word was dropped because the holding register was full.
- frame_err  output  1  sticky; a partial word was abandoned by a new frame_start.
- clear_flags  input  1  synchronous clear of overflow and frame_err.

Behaviour:
- Reset (async, while reset=1):
  - state=IDLE, shift register=0, bit counter=0.
  - data_out=0, data_valid=0, busy=0, overflow=0, frame_err=0.
  - Reset mid-word discards the partial word and any held word.
- State IDLE:
  - bit_valid=1 and frame_start=1: capture serial_in as the first bit, counter=1, go to SHIFT.
  - bit_valid=1 and frame_start=0: ignore the bit (hunting for a frame). No flag is set.
- State SHIFT:
  - bit_valid=0: hold state, counter and shift register. Gaps of any length are legal.
  - bit_valid=1, frame_start=0, counter<WIDTH-1: shift the bit in, counter+1.
  - bit_valid=1, frame_start=0, counter==WIDTH-1: this is the last bit. The word is complete and the full word including this bit goes to the completion logic. Counter=0, go to IDLE.
  - bit_valid=1, frame_start=1 (resync): discard the partial word and set frame_err. Capture this bit as the first bit of a new word, counter=1, stay in SHIFT.
- Bit placement:
  - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
- Completion and latency:
  - The last bit is sampled at edge N.
  - data_out and data_valid=1 are visible after edge N, i.e. zero extra pipeline cycles beyond the sampling edge.
- Output handshake:
  - data_valid stays 1 and data_out stays stable until a cycle with data_valid=1 and data_ready=1. data_valid clears at that edge.
  - data_ready while data_valid=0 has no effect.
- Completion with the holding register occupied:
  - data_valid=1 and data_ready=0 in the completion cycle: drop the new word, keep the old data_out, set overflow.
  - data_valid=1 and data_ready=1 in the completion cycle: the old word is consumed and the new word loaded on the same edge. data_valid stays 1. No overflow.
- Flags:
  - overflow and frame_err are sticky until clear_flags=1.
  - If a set event and clear_flags occur in the same cycle, set wins.
- busy = (state==SHIFT).
- The counter width is enough to hold WIDTH-1. There are no other arithmetic paths.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, data_ready=1. Release reset, then stream 1,0,1,0,1,0,1,0 on consecutive cycles with frame_start on the first bit.
   - Expect data_out=8'hAA and data_valid=1 for exactly one cycle, right after the 8th bit edge.
   - busy=1 from after the 1st bit until after the 8th.
2. Same word 0xAA with 1–3 idle cycles (bit_valid=0) between bits, plus two bit_valid=1 cycles with frame_start=0 before the frame starts.
   - Expect data_out=8'hAA.
   - Bits before frame_start are ignored; no flags set.
3. data_ready=0. Send 0x3C, then 0xC3.
   - Expect data_out=8'h3C held, data_valid=1, overflow=1.
   - Raise data_ready for one cycle: data_valid drops.
   - clear_flags: overflow=0.
4. Send 3 bits of a word, then frame_start with a full 0x5A.
   - Expect data_out=8'h5A and frame_err=1.
   - Also: completion coincident with data_ready=1 on a pending 0x11 gives data_out=0x5A, data_valid stays 1, overflow=0.
5. Assert reset after 4 bits of a word.
   - Expect all outputs 0 immediately (async).
   - After release, a full 0xF0 is received correctly.
6. MSB_FIRST=0. Stream 0x96 LSB first (0,1,1,0,1,0,0,1).
   - Expect data_out=8'h96.
